// File: rtl/masked_and_scheduler_pkg.sv
// ============================================================================
// Module   : masked_and_pkg
// Purpose  : Shared types, share count and index helper for the masked AND
//            scheduler.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package masked_and_pkg;

    localparam int SHARES = 2;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WAIT_RND = 3'd1,
        MUL      = 3'd2,
        COMP     = 3'd3,
        HOLD     = 3'd4,
        PRE      = 3'd5
    } sched_state_t;

    // Modular increment used by the round-robin search and pointer update.
    function automatic int wrap_add(input int base, input int off, input int n);
        return (base + off) % n;
    endfunction

endpackage

`default_nettype wire

// File: rtl/masked_and_scheduler_if.sv
// ============================================================================
// Module   : masked_and_scheduler_if
// Purpose  : Requester, randomness and response handshakes of the masked AND
//            scheduler. The master modport is the client/PRNG side.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface masked_and_scheduler_if
    import masked_and_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [SHARES*NUM_REQ-1:0] req_a;
    logic [SHARES*NUM_REQ-1:0] req_b;
    logic                      rnd_valid;
    logic                      rnd_ready;
    logic                      rnd_in;
    logic                      rsp_valid;
    logic                      rsp_ready;
    logic [ID_W-1:0]           rsp_id;
    logic [SHARES-1:0]         rsp_c;

    modport master (
        output req_valid, req_a, req_b, rnd_valid, rnd_in, rsp_ready,
        input  req_ready, rnd_ready, rsp_valid, rsp_id, rsp_c
    );

    modport slave (
        input  req_valid, req_a, req_b, rnd_valid, rnd_in, rsp_ready,
        output req_ready, rnd_ready, rsp_valid, rsp_id, rsp_c
    );

endinterface

`default_nettype wire

// File: rtl/masked_and_scheduler_isw_and_d1_reg.sv
// ============================================================================
// Module   : isw_and_d1_reg
// Purpose  : First-order ISW AND datapath: registered partial products, then
//            registered compression into the output shares.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module isw_and_d1_reg
    import masked_and_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              mul_en,
    input  wire logic              comp_en,
    input  wire logic              clr,
    input  wire logic [SHARES-1:0] a,
    input  wire logic [SHARES-1:0] b,
    input  wire logic              r,
    output logic      [SHARES-1:0] c
);

    logic r_p0;
    logic r_p1;
    logic r_p01;
    logic r_p10;
    logic [SHARES-1:0] r_c;

    // Every cross term gets its own flop so no two shares of one operand
    // meet in combinational logic before the refresh bit is absorbed.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_p0  <= 1'b0;
            r_p1  <= 1'b0;
            r_p01 <= 1'b0;
            r_p10 <= 1'b0;
            r_c   <= '0;
        end else begin
            if (clr) begin
                r_p0  <= 1'b0;
                r_p1  <= 1'b0;
                r_p01 <= 1'b0;
                r_p10 <= 1'b0;
            end else if (mul_en) begin
                r_p0  <= (a[0] & b[0]) ^ r;
                r_p1  <= (a[1] & b[1]) ^ r;
                r_p01 <= a[0] & b[1];
                r_p10 <= a[1] & b[0];
            end
            if (comp_en) begin
                r_c[0] <= r_p0;
                r_c[1] <= (r_p1 ^ r_p01) ^ r_p10;
            end
        end
    end

    assign c = r_c;

endmodule

`default_nettype wire

// File: rtl/masked_and_scheduler.sv
// ============================================================================
// Module   : masked_and_scheduler
// Purpose  : Round-robin sharing of one registered ISW masked AND core among
//            NUM_REQ requesters. Optional macro PRECHARGE_EN adds a PRE state
//            that zeroes operand/random/partial-product registers between ops.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module masked_and_scheduler
    import masked_and_pkg::*;
#(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
)(
    input  wire logic               clk,
    input  wire logic               rst,
    masked_and_scheduler_if.slave   bus
);

    sched_state_t      r_state;
    logic [ID_W-1:0]   r_rr;
    logic [ID_W-1:0]   r_id;
    logic [SHARES-1:0] r_a;
    logic [SHARES-1:0] r_b;
    logic              r_rnd;
    logic              r_rsp_valid;

    logic              w_grant_valid;
    logic [ID_W-1:0]   w_grant_id;
    logic [SHARES-1:0] w_sel_a;
    logic [SHARES-1:0] w_sel_b;
    logic [NUM_REQ-1:0] w_req_ready;
    logic              w_mul_en;
    logic              w_comp_en;
    logic              w_clr;
    logic [SHARES-1:0] w_rsp_c;

    // Search downward so the last hit is the first valid at/after r_rr.
    always_comb begin
        w_grant_valid = 1'b0;
        w_grant_id    = '0;
        w_sel_a       = '0;
        w_sel_b       = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[wrap_add(int'(r_rr), k, NUM_REQ)]) begin
                w_grant_valid = 1'b1;
                w_grant_id    = ID_W'(wrap_add(int'(r_rr), k, NUM_REQ));
                w_sel_a       = bus.req_a[SHARES*wrap_add(int'(r_rr), k, NUM_REQ) +: SHARES];
                w_sel_b       = bus.req_b[SHARES*wrap_add(int'(r_rr), k, NUM_REQ) +: SHARES];
            end
        end
    end

    always_comb begin
        w_req_ready = '0;
        if (r_state == IDLE && w_grant_valid) begin
            w_req_ready[w_grant_id] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_rr        <= '0;
            r_id        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_rnd       <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant_valid) begin
                        r_a     <= w_sel_a;
                        r_b     <= w_sel_b;
                        r_id    <= w_grant_id;
                        r_rr    <= ID_W'(wrap_add(int'(w_grant_id), 1, NUM_REQ));
                        r_state <= WAIT_RND;
                    end
                end
                WAIT_RND: begin
                    if (bus.rnd_valid) begin
                        r_rnd   <= bus.rnd_in;
                        r_state <= MUL;
                    end
                end
                MUL: begin
                    r_state <= COMP;
                end
                COMP: begin
                    r_rsp_valid <= 1'b1;
                    r_state     <= HOLD;
                end
                HOLD: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
`ifdef PRECHARGE_EN
                        // Zeroed on the way into PRE so PRE itself sees 0s.
                        r_a     <= '0;
                        r_b     <= '0;
                        r_rnd   <= 1'b0;
                        r_state <= PRE;
`else
                        r_state <= IDLE;
`endif
                    end
                end
`ifdef PRECHARGE_EN
                PRE: begin
                    r_state <= IDLE;
                end
`endif
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign w_mul_en  = (r_state == MUL);
    assign w_comp_en = (r_state == COMP);
`ifdef PRECHARGE_EN
    assign w_clr     = (r_state == HOLD) && bus.rsp_ready;
`else
    assign w_clr     = 1'b0;
`endif

    isw_and_d1_reg u_isw (
        .clk     (clk),
        .rst     (rst),
        .mul_en  (w_mul_en),
        .comp_en (w_comp_en),
        .clr     (w_clr),
        .a       (r_a),
        .b       (r_b),
        .r       (r_rnd),
        .c       (w_rsp_c)
    );

    assign bus.req_ready = w_req_ready;
    assign bus.rnd_ready = (r_state == WAIT_RND);
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_c     = w_rsp_c;

endmodule

`default_nettype wire
